ks_wide_add_ctrl: RTL
=====================

KS_WIDE_ADD_CTRL -- requirements
Module: ks_wide_add_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, limb width equal to the registered Kogge-Stone adder (KG_TOP) operand width.
REQ-002 Parameter: LIMBS, default 4, number of limbs per wide operand, giving WIDE = DATA_WIDTH*LIMBS.
REQ-003 Parameter: ADD_LAT, default 2, cycles from operands driven to the matching add_s being valid.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  wide operand request.
REQ-007 in_ready  out  1  block can accept a request.
REQ-008 in_a, in_b  in  WIDE  wide operands.
REQ-009 in_cin  in  1  carry into limb 0.
REQ-010 add_a, add_b  out  DATA_WIDTH  limb operands driven to KG_TOP A/B.
REQ-011 add_cin  out  1  limb carry driven to KG_TOP Cin.
REQ-012 add_s  in  DATA_WIDTH+1  KG_TOP S: sum bits plus carry-out in the MSB.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 out_sum  out  WIDE  wide sum.
REQ-016 out_cout  out  1  final carry out.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT, CAPT and DONE.
REQ-018 in_ready SHALL equal 1 only in IDLE; in_valid SHALL be ignored in all other states.
REQ-019 In IDLE with in_valid=1, the block SHALL register in_a, in_b and in_cin, clear the limb index to 0 and go to ISSUE.
REQ-020 In ISSUE, add_a/add_b SHALL carry limb[idx] of the registered operands and add_cin SHALL carry the running carry.
REQ-021 add_a, add_b and add_cin SHALL be driven from registers and held stable until the next ISSUE.
REQ-022 ISSUE SHALL go to WAIT for ADD_LAT-1 cycles (a down-counter), then to CAPT.
REQ-023 In CAPT, add_s[DATA_WIDTH-1:0] SHALL be written into out_sum limb[idx], and add_s[DATA_WIDTH] SHALL become the running carry.
REQ-024 From CAPT, if idx = LIMBS-1 the FSM SHALL go to DONE with out_cout equal to add_s[DATA_WIDTH]; otherwise idx SHALL increment and the FSM SHALL go to ISSUE.
REQ-025 With the defaults, out_valid SHALL first be 1 in the 13th cycle after the accepting cycle (3 cycles per limb, plus 1).
REQ-026 out_valid SHALL equal 1 only in DONE; out_sum and out_cout SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 In DONE with out_ready=1, the FSM SHALL go to IDLE; a new request is accepted no earlier than the following cycle, giving at most 1 result per 14 cycles.
REQ-028 Wide addition SHALL be modulo 2^WIDE with the carry in out_cout; carries SHALL ripple across all limbs.
REQ-029 out_sum and out_cout SHALL retain their last result in IDLE until overwritten limb-by-limb by the next operation.

Reset
REQ-030 While rst=1, the block SHALL hold: state IDLE, idx 0, running carry 0, add_a/add_b/add_cin 0, out_sum 0, out_cout 0, out_valid 0, in_ready 0.
REQ-031 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-032 rst asserted mid-operation SHALL abandon the operation with no out_valid pulse.
REQ-033 Any add_s value still in flight after reset SHALL be discarded, because capture occurs only in CAPT.
REQ-034 rst SHALL take priority over every handshake.

Structure
REQ-035 Package ks_pkg SHALL hold DATA_WIDTH, LIMBS, ADD_LAT, WIDE and the FSM state enumeration.
REQ-036 The block SHALL have no sub-module.
REQ-037 A separate wrapper, ks_wide_top, SHALL instantiate this block and KG_TOP on the shared clk/rst.

Verification
REQ-038 Reset: hold rst=1 for 3 cycles -> all outputs 0; in_ready=1 on the first cycle after release.
REQ-039 Simple add: a=1, b=2, cin=0 -> out_sum=3, out_cout=0, out_valid on cycle 13 after accept.
REQ-040 Full ripple: a=all-ones (128-bit), b=0, cin=1 -> out_sum=0, out_cout=1, and add_cin=1 observed on every limb issue.
REQ-041 Backpressure: hold out_ready=0 for 5 cycles in DONE with a=0x...FFFF_FFFF, b=1 -> out_sum=0x1_0000_0000 held stable, in_ready=0 throughout, then IDLE after out_ready=1.
REQ-042 Busy request: pulse in_valid with new operands during WAIT -> ignored; the result matches the original operands.
REQ-043 Mid-operation reset: assert rst during limb-2 CAPT -> no out_valid; a following add a=5, b=7 -> out_sum=12.

Source files
------------

// File: rtl/ks_pkg.sv
// Shared sizing constants and FSM encoding for the wide Kogge-Stone add controller.
package ks_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int LIMBS      = 4;
    localparam int ADD_LAT    = 2;
    localparam int WIDE       = DATA_WIDTH * LIMBS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CAPT  = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int clog2_min1(input int value);
        int bits;
        bits = $clog2(value);
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/KG_TOP.sv
// Registered Kogge-Stone adder: operands registered, prefix tree, sum registered.
// Two cycles from operands driven to the matching S.
module KG_TOP #(
    parameter int W = ks_pkg::DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    output logic [W:0]   S
);

    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         cin_q;
    logic [W:0]   s_q;
    logic [W:0]   sum_s;

    // Carry-in is folded into bit 0's generate so the prefix tree yields final carries.
    function automatic logic [W:0] ks_sum(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic         cin);
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W-1:0] gn;
        logic [W-1:0] pn;
        logic [W-1:0] x;
        logic [W-1:0] c;
        x = a ^ b;
        g = a & b;
        p = x;
        g[0] = g[0] | (p[0] & cin);
        for (int d = 1; d < W; d = d * 2) begin
            gn = g;
            pn = p;
            for (int i = d; i < W; i++) begin
                gn[i] = g[i] | (p[i] & g[i-d]);
                pn[i] = p[i] & p[i-d];
            end
            g = gn;
            p = pn;
        end
        c = {g[W-2:0], cin};
        return {g[W-1], x ^ c};
    endfunction

    // Prefix evaluation on the registered operands.
    always_comb begin
        sum_s = ks_sum(a_q, b_q, cin_q);
    end

    // Operand stage and result stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            s_q   <= '0;
        end else begin
            a_q   <= A;
            b_q   <= B;
            cin_q <= Cin;
            s_q   <= sum_s;
        end
    end

    assign S = s_q;

endmodule

// File: rtl/ks_wide_top.sv
// Wide adder: the limb-sequencing controller paired with the registered Kogge-Stone adder.
module ks_wide_top #(
    parameter int  DATA_WIDTH = ks_pkg::DATA_WIDTH,
    parameter int  LIMBS      = ks_pkg::LIMBS,
    parameter int  ADD_LAT    = ks_pkg::ADD_LAT,
    localparam int WIDE       = DATA_WIDTH * LIMBS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WIDE-1:0] in_a,
    input  logic [WIDE-1:0] in_b,
    input  logic            in_cin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WIDE-1:0] out_sum,
    output logic            out_cout
);

    logic [DATA_WIDTH-1:0] add_a_s;
    logic [DATA_WIDTH-1:0] add_b_s;
    logic                  add_cin_s;
    logic [DATA_WIDTH:0]   add_s_s;

    ks_wide_add_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .LIMBS      (LIMBS),
        .ADD_LAT    (ADD_LAT)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a_s),
        .add_b     (add_b_s),
        .add_cin   (add_cin_s),
        .add_s     (add_s_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    KG_TOP #(
        .W (DATA_WIDTH)
    ) u_adder (
        .clk (clk),
        .rst (rst),
        .A   (add_a_s),
        .B   (add_b_s),
        .Cin (add_cin_s),
        .S   (add_s_s)
    );

endmodule

// File: rtl/ks_wide_add_ctrl.sv
// Sequences a wide add through an external pipelined limb adder, one limb at a
// time from limb 0 upward, rippling the carry between limbs.
module ks_wide_add_ctrl #(
    parameter int  DATA_WIDTH = ks_pkg::DATA_WIDTH,
    parameter int  LIMBS      = ks_pkg::LIMBS,
    parameter int  ADD_LAT    = ks_pkg::ADD_LAT,
    localparam int WIDE       = DATA_WIDTH * LIMBS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDE-1:0]       in_a,
    input  logic [WIDE-1:0]       in_b,
    input  logic                  in_cin,
    output logic [DATA_WIDTH-1:0] add_a,
    output logic [DATA_WIDTH-1:0] add_b,
    output logic                  add_cin,
    input  logic [DATA_WIDTH:0]   add_s,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDE-1:0]       out_sum,
    output logic                  out_cout
);
    import ks_pkg::*;

    localparam int IDXW = clog2_min1(LIMBS);
    localparam int CNTW = clog2_min1(ADD_LAT);

    state_e                               state_q, state_d;
    logic [IDXW-1:0]                      idx_q, idx_d, idx_nxt_s;
    logic [CNTW-1:0]                      cnt_q, cnt_d;
    logic [LIMBS-1:0][DATA_WIDTH-1:0]     a_q, a_d;
    logic [LIMBS-1:0][DATA_WIDTH-1:0]     b_q, b_d;
    logic [LIMBS-1:0][DATA_WIDTH-1:0]     sum_q, sum_d;
    logic [DATA_WIDTH-1:0]                add_a_q, add_a_d;
    logic [DATA_WIDTH-1:0]                add_b_q, add_b_d;
    logic                                 add_cin_q, add_cin_d;
    logic                                 cout_q, cout_d;
    logic                                 in_ready_q, in_ready_d;
    logic                                 out_valid_q, out_valid_d;

    assign idx_nxt_s = idx_q + IDXW'(1);

    // Next-state logic; add_cin_q doubles as the running carry, and the limb
    // operands are loaded on entry to ISSUE so they are stable for the whole issue.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_ready_q && in_valid) begin
                    a_d        = in_a;
                    b_d        = in_b;
                    idx_d      = '0;
                    add_a_d    = in_a[DATA_WIDTH-1:0];
                    add_b_d    = in_b[DATA_WIDTH-1:0];
                    add_cin_d  = in_cin;
                    in_ready_d = 1'b0;
                    state_d    = ISSUE;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ISSUE: begin
                if (ADD_LAT > 1) begin
                    cnt_d   = CNTW'(ADD_LAT - 2);
                    state_d = WAIT;
                end else begin
                    state_d = CAPT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = CAPT;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            CAPT: begin
                sum_d[idx_q] = add_s[DATA_WIDTH-1:0];
                add_cin_d    = add_s[DATA_WIDTH];
                if (idx_q == IDXW'(LIMBS - 1)) begin
                    cout_d      = add_s[DATA_WIDTH];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d   = idx_nxt_s;
                    add_a_d = a_q[idx_nxt_s];
                    add_b_d = b_q[idx_nxt_s];
                    state_d = ISSUE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule
